// File: rtl/ga_multi_issue_queue.sv
// GA execution front end: round-robin arbitration over several requesters, an in-order
// issue FIFO toward the ALU with a bounded number of outstanding ops, and tag-routed responses.
module ga_multi_issue_queue #(
  parameter int unsigned NumChannels    = 4,
  parameter int unsigned Depth          = 4,
  parameter int unsigned ReqWidth       = 64,
  parameter int unsigned RespWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned TagWidth      = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumChannels-1:0]          req_valid_i,
  output logic [NumChannels-1:0]          req_ready_o,
  input  logic [NumChannels*ReqWidth-1:0] req_data_i,
  input  logic                            flush_i,
  output logic                            alu_valid_o,
  input  logic                            alu_ready_i,
  output logic [ReqWidth-1:0]             alu_data_o,
  output logic [TagWidth-1:0]             alu_tag_o,
  input  logic                            alu_resp_valid_i,
  input  logic [TagWidth-1:0]             alu_resp_tag_i,
  input  logic [RespWidth-1:0]            alu_resp_data_i,
  input  logic                            alu_resp_error_i,
  output logic [NumChannels-1:0]          resp_valid_o,
  output logic [RespWidth-1:0]            resp_data_o,
  output logic                            resp_error_o,
  output logic                            busy_o,
  output logic [31:0]                     issued_cnt_o,
  output logic [31:0]                     stall_cnt_o
);

  localparam int unsigned AddrWidth = $clog2(Depth);
  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxOutVal = CntWidth'(MaxOutstanding);

  logic [AddrWidth:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ReqWidth-1:0]    fifo_data_q [Depth];
  logic [ReqWidth-1:0]    fifo_data_d [Depth];
  logic [TagWidth-1:0]    fifo_tag_q  [Depth];
  logic [TagWidth-1:0]    fifo_tag_d  [Depth];
  logic [TagWidth-1:0]    rr_q, rr_d;
  logic [CntWidth-1:0]    out_cnt_q, out_cnt_d;
  logic [NumChannels-1:0] resp_valid_q, resp_valid_d;
  logic [RespWidth-1:0]   resp_data_q, resp_data_d;
  logic                   resp_error_q, resp_error_d;
  logic [31:0]            issued_cnt_q, issued_cnt_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  logic [AddrWidth-1:0]   wr_idx_s, rd_idx_s;
  logic                   fifo_empty_s, fifo_full_s;
  logic [NumChannels-1:0] grant_s;
  logic [TagWidth-1:0]    grant_tag_s;
  logic                   grant_any_s;
  logic [ReqWidth-1:0]    push_data_s;
  int unsigned            rr_int_s;
  logic                   push_s, issue_s, resp_ok_s, resp_hit_s;

  assign wr_idx_s     = wr_ptr_q[AddrWidth-1:0];
  assign rd_idx_s     = rd_ptr_q[AddrWidth-1:0];
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]) &&
                        (wr_idx_s == rd_idx_s);

  // Round-robin pick: first valid channel at or after rr_q, with its payload.
  always_comb begin
    grant_s     = '0;
    grant_tag_s = '0;
    grant_any_s = 1'b0;
    push_data_s = '0;
    rr_int_s    = 32'(rr_q);
    for (int unsigned i = 0; i < NumChannels; i++) begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        logic hit;
        hit = !grant_any_s && (c == ((rr_int_s + i) % NumChannels)) && req_valid_i[c];
        grant_s[c]  = grant_s[c] | hit;
        grant_tag_s = hit ? TagWidth'(c) : grant_tag_s;
        push_data_s = hit ? req_data_i[c*ReqWidth +: ReqWidth] : push_data_s;
        grant_any_s = grant_any_s | hit;
      end
    end
  end

  assign push_s      = grant_any_s && !fifo_full_s && !flush_i;
  assign req_ready_o = push_s ? grant_s : '0;
  assign alu_valid_o = !fifo_empty_s && (out_cnt_q < MaxOutVal);
  assign issue_s     = alu_valid_o && alu_ready_i;
  // A response with nothing outstanding (e.g. straggler after reset) is dropped entirely.
  assign resp_ok_s   = alu_resp_valid_i && (out_cnt_q != '0);
  assign alu_data_o  = fifo_data_q[rd_idx_s];
  assign alu_tag_o   = fifo_tag_q[rd_idx_s];
  assign busy_o      = !fifo_empty_s || (out_cnt_q != '0);

  // FIFO storage and pointers; flush wins over a same-cycle pop.
  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      fifo_data_d[i] = (push_s && (wr_idx_s == AddrWidth'(i))) ? push_data_s : fifo_data_q[i];
      fifo_tag_d[i]  = (push_s && (wr_idx_s == AddrWidth'(i))) ? grant_tag_s : fifo_tag_q[i];
    end
    wr_ptr_d = push_s ? (wr_ptr_q + (AddrWidth+1)'(1)) : wr_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else if (issue_s) begin
      rd_ptr_d = rd_ptr_q + (AddrWidth+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Arbitration pointer advances past the channel just accepted.
  always_comb begin
    rr_d = rr_q;
    if (flush_i) begin
      rr_d = '0;
    end else if (push_s) begin
      rr_d = (grant_tag_s == TagWidth'(NumChannels - 1)) ? '0 : (grant_tag_s + TagWidth'(1));
    end else begin
      rr_d = rr_q;
    end
  end

  // Outstanding count, routed response capture and performance counters.
  always_comb begin
    case ({issue_s, resp_ok_s})
      2'b10:   out_cnt_d = out_cnt_q + CntWidth'(1);
      2'b01:   out_cnt_d = out_cnt_q - CntWidth'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
    for (int unsigned c = 0; c < NumChannels; c++) begin
      resp_valid_d[c] = resp_ok_s && (alu_resp_tag_i == TagWidth'(c));
    end
    resp_hit_s   = |resp_valid_d;
    resp_data_d  = resp_hit_s ? alu_resp_data_i : resp_data_q;
    resp_error_d = resp_hit_s ? alu_resp_error_i : resp_error_q;
    issued_cnt_d = issue_s ? (issued_cnt_q + 32'd1) : issued_cnt_q;
    stall_cnt_d  = (!fifo_empty_s && !issue_s) ? (stall_cnt_q + 32'd1) : stall_cnt_q;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rr_q         <= '0;
      out_cnt_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      issued_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
      for (int unsigned i = 0; i < Depth; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rr_q         <= rr_d;
      out_cnt_q    <= out_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      issued_cnt_q <= issued_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      fifo_data_q  <= fifo_data_d;
      fifo_tag_q   <= fifo_tag_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_error_o = resp_error_q;
  assign issued_cnt_o = issued_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_ga_multi_issue_queue.sv
// Self-checking bench for ga_multi_issue_queue: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_ga_multi_issue_queue;
  localparam int NC = 4;
  localparam int DEPTH = 4;
  localparam int RW = 64;
  localparam int PW = 32;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NC-1:0] req_valid;
  logic [NC*RW-1:0] req_data;
  logic flush, alu_ready, resp_v, resp_err;
  logic [1:0] resp_tag;
  logic [PW-1:0] resp_data;
  logic [NC-1:0] req_ready_o, resp_valid_o;
  logic alu_valid_o, resp_error_o, busy_o;
  logic [RW-1:0] alu_data_o;
  logic [1:0] alu_tag_o;
  logic [PW-1:0] resp_data_o;
  logic [31:0] issued_cnt_o, stall_cnt_o;

  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  logic [RW-1:0] mq_data[$];
  int mq_tag[$];
  int m_rr, m_out;
  logic [31:0] m_issued, m_stall, m_rd;
  logic [NC-1:0] m_rv;
  logic m_re;

  always #5 clk = ~clk;

  ga_multi_issue_queue #(.NumChannels(NC), .Depth(DEPTH), .ReqWidth(RW),
                         .RespWidth(PW), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_data_i(req_data), .flush_i(flush), .alu_valid_o(alu_valid_o),
    .alu_ready_i(alu_ready), .alu_data_o(alu_data_o), .alu_tag_o(alu_tag_o),
    .alu_resp_valid_i(resp_v), .alu_resp_tag_i(resp_tag), .alu_resp_data_i(resp_data),
    .alu_resp_error_i(resp_err), .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .resp_error_o(resp_error_o), .busy_o(busy_o), .issued_cnt_o(issued_cnt_o),
    .stall_cnt_o(stall_cnt_o));

  task automatic model_reset();
    mq_data.delete(); mq_tag.delete();
    m_rr = 0; m_out = 0; m_issued = 32'd0; m_stall = 32'd0;
    m_rd = 32'd0; m_rv = 4'd0; m_re = 1'b0;
  endtask

  function automatic int m_grant();
    for (int i = 0; i < NC; i++) begin
      if (req_valid[(m_rr + i) % NC]) return (m_rr + i) % NC;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] m_ready();
    int g;
    g = m_grant();
    if (g >= 0 && mq_data.size() < DEPTH && !flush) return 4'b0001 << g;
    return 4'b0000;
  endfunction

  function automatic logic m_alu_valid();
    return (mq_data.size() > 0) && (m_out < MAXO);
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_tick();
    int g;
    bit push, issue, rok;
    g = m_grant();
    push = (g >= 0) && (mq_data.size() < DEPTH) && !flush;
    issue = m_alu_valid() && alu_ready;
    rok = resp_v && (m_out > 0);
    if (mq_data.size() > 0 && !issue) m_stall++;
    if (issue) m_issued++;
    m_rv = 4'd0;
    if (rok && resp_tag < NC) begin
      m_rv[resp_tag] = 1'b1; m_rd = resp_data; m_re = resp_err;
    end
    if (flush) begin
      mq_data.delete(); mq_tag.delete(); m_rr = 0;
    end else begin
      if (issue) begin void'(mq_data.pop_front()); void'(mq_tag.pop_front()); end
      if (push) begin
        mq_data.push_back(req_data[g*RW +: RW]); mq_tag.push_back(g); m_rr = (g + 1) % NC;
      end
    end
    if (issue && !rok) m_out++;
    else if (!issue && rok) m_out--;
  endtask

  task automatic cycle();
    model_tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_req_data();
    for (int c = 0; c < NC; c++) req_data[c*RW +: RW] = {$urandom, $urandom};
  endtask

  task automatic clear_inputs();
    req_valid = 4'd0; req_data = '0; flush = 1'b0; alu_ready = 1'b0;
    resp_v = 1'b0; resp_tag = 2'd0; resp_data = 32'd0; resp_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear_inputs();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_inputs();
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({alu_valid_o, resp_valid_o, resp_data_o, resp_error_o, busy_o, issued_cnt_o,
         stall_cnt_o, req_ready_o, alu_data_o, alu_tag_o} !== '0)
      $display("FAIL reset_outputs: valid=%b rv=%b rd=%h re=%b busy=%b iss=%0d stall=%0d rdy=%b data=%h tag=%0d, all required 0",
               alu_valid_o, resp_valid_o, resp_data_o, resp_error_o, busy_o, issued_cnt_o,
               stall_cnt_o, req_ready_o, alu_data_o, alu_tag_o);
    else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1; model_reset();
    cycle(); @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || alu_valid_o !== 1'b0)
      $display("FAIL reset_idle: busy=%b alu_valid=%b required 0 0", busy_o, alu_valid_o);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int exp_g[5];
    logic prev_issue;
    logic [1:0] prev_tag;
    exp_g = '{0, 1, 2, 3, 0};
    do_reset(); alu_ready = 1'b1; rand_req_data();
    prev_issue = 1'b0; prev_tag = 2'd0;
    for (int k = 0; k < 9; k++) begin
      req_valid = (k < 5) ? 4'hF : 4'h0;
      resp_v = prev_issue; resp_tag = prev_tag; resp_data = $urandom;
      @(negedge clk);
      if (k < 5) begin
        n_checks++;
        if (req_ready_o !== (4'b0001 << exp_g[k]))
          $display("FAIL rr_grant k=%0d: got %b required %b", k, req_ready_o, 4'b0001 << exp_g[k]);
        else n_pass++;
      end
      if (k >= 1 && k <= 4) begin
        n_checks++;
        if (alu_valid_o !== 1'b1 || alu_tag_o !== 2'(k - 1))
          $display("FAIL rr_tag k=%0d: valid=%b tag=%0d required 1 %0d", k, alu_valid_o, alu_tag_o, k - 1);
        else n_pass++;
      end
      if (k == 5) begin
        n_checks++;
        if (issued_cnt_o !== 32'd4)
          $display("FAIL rr_issued: got %0d required 4", issued_cnt_o);
        else n_pass++;
      end
      prev_issue = alu_valid_o && alu_ready; prev_tag = alu_tag_o;
      cycle();
    end
  endtask

  task automatic test_full_fifo();
    logic [RW-1:0] dd[NC];
    logic prev_issue;
    logic [1:0] prev_tag;
    do_reset(); rand_req_data();
    for (int c = 0; c < NC; c++) dd[c] = req_data[c*RW +: RW];
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 5) ? 4'hF : 4'h0;
      @(negedge clk);
      if (k <= 4) begin
        n_checks++;
        if (req_ready_o !== ((k < 4) ? (4'b0001 << k) : 4'b0000))
          $display("FAIL full_ready k=%0d: got %b required %b", k, req_ready_o,
                   (k < 4) ? (4'b0001 << k) : 4'b0000);
        else n_pass++;
      end
      n_checks++;
      if (stall_cnt_o !== ((k == 0) ? 32'd0 : 32'(k - 1)))
        $display("FAIL full_stall k=%0d: got %0d required %0d", k, stall_cnt_o, (k == 0) ? 0 : k - 1);
      else n_pass++;
      cycle();
    end
    alu_ready = 1'b1; prev_issue = 1'b0; prev_tag = 2'd0;
    for (int k = 0; k < 6; k++) begin
      resp_v = prev_issue; resp_tag = prev_tag; resp_data = $urandom;
      @(negedge clk);
      if (k < 4) begin
        n_checks++;
        if (alu_valid_o !== 1'b1 || alu_tag_o !== 2'(k) || alu_data_o !== dd[k])
          $display("FAIL drain_order k=%0d: valid=%b tag=%0d data=%h required 1 %0d %h",
                   k, alu_valid_o, alu_tag_o, alu_data_o, k, dd[k]);
        else n_pass++;
      end
      prev_issue = alu_valid_o && alu_ready; prev_tag = alu_tag_o;
      cycle();
    end
    @(negedge clk);
    n_checks++;
    if (stall_cnt_o !== 32'd7 || busy_o !== 1'b0 || issued_cnt_o !== 32'd4)
      $display("FAIL drain_end: stall=%0d busy=%b issued=%0d required 7 0 4", stall_cnt_o, busy_o, issued_cnt_o);
    else n_pass++;
  endtask

  task automatic test_outstanding_limit();
    logic [RW-1:0] dd[3];
    logic [PW-1:0] rdat;
    do_reset(); alu_ready = 1'b1; rdat = $urandom;
    for (int k = 0; k < 9; k++) begin
      req_valid = (k < 3) ? 4'b0100 : 4'b0000;
      if (k < 3) begin dd[k] = {$urandom, $urandom}; req_data[2*RW +: RW] = dd[k]; end
      resp_v = (k == 6); resp_tag = 2'd2; resp_data = rdat; resp_err = 1'b0;
      @(negedge clk);
      if (k >= 3 && k <= 6) begin
        n_checks++;
        if (alu_valid_o !== 1'b0)
          $display("FAIL limit_block k=%0d: alu_valid=%b required 0", k, alu_valid_o);
        else n_pass++;
      end
      if (k == 6) begin
        n_checks++;
        if (issued_cnt_o !== 32'd2) $display("FAIL limit_issued: got %0d required 2", issued_cnt_o);
        else n_pass++;
      end
      if (k == 7) begin
        n_checks++;
        if (resp_valid_o !== 4'b0100 || resp_data_o !== rdat)
          $display("FAIL limit_resp: rv=%b data=%h required 0100 %h", resp_valid_o, resp_data_o, rdat);
        else n_pass++;
        n_checks++;
        if (alu_valid_o !== 1'b1 || alu_data_o !== dd[2])
          $display("FAIL limit_resume: valid=%b data=%h required 1 %h", alu_valid_o, alu_data_o, dd[2]);
        else n_pass++;
      end
      cycle();
    end
  endtask

  task automatic test_flush();
    do_reset(); rand_req_data();
    for (int k = 0; k < 9; k++) begin
      req_valid = (k < 4) ? 4'b0010 : (k == 4) ? 4'b1000 : (k == 8) ? 4'b1111 : 4'b0000;
      alu_ready = (k == 1);
      flush = (k == 4);
      resp_v = (k == 6); resp_tag = 2'd1; resp_data = 32'hC0DE_0001;
      @(negedge clk);
      case (k)
        1: begin
          n_checks++;
          if (req_ready_o !== 4'b0010 || alu_valid_o !== 1'b1)
            $display("FAIL flush_setup: rdy=%b valid=%b required 0010 1", req_ready_o, alu_valid_o);
          else n_pass++;
        end
        4: begin
          n_checks++;
          if (req_ready_o !== 4'b0000) $display("FAIL flush_block_push: got %b required 0000", req_ready_o);
          else n_pass++;
        end
        5: begin
          n_checks++;
          if (alu_valid_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL flush_empty: valid=%b busy=%b required 0 1", alu_valid_o, busy_o);
          else n_pass++;
        end
        7: begin
          n_checks++;
          if (resp_valid_o !== 4'b0010 || busy_o !== 1'b0)
            $display("FAIL flush_resp: rv=%b busy=%b required 0010 0", resp_valid_o, busy_o);
          else n_pass++;
        end
        8: begin
          n_checks++;
          if (req_ready_o !== 4'b0001) $display("FAIL flush_rr: got %b required 0001", req_ready_o);
          else n_pass++;
        end
        default: ;
      endcase
      cycle();
    end
  endtask

  task automatic test_simultaneous();
    logic [PW-1:0] da;
    do_reset(); alu_ready = 1'b1; da = $urandom;
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 5) ? 4'b0001 : 4'b0000;
      req_data[RW-1:0] = {$urandom, $urandom};
      resp_v = (k == 3) || (k == 4);
      resp_tag = (k == 3) ? 2'd3 : 2'd0;
      resp_err = (k == 3);
      resp_data = (k == 3) ? da : 32'h0;
      @(negedge clk);
      if (k == 3 || k == 6) begin
        n_checks++;
        if (alu_valid_o !== 1'b0 || busy_o !== 1'b1)
          $display("FAIL sim_at_limit k=%0d: valid=%b busy=%b required 0 1", k, alu_valid_o, busy_o);
        else n_pass++;
      end
      if (k == 4) begin
        n_checks++;
        if (resp_valid_o !== 4'b1000 || resp_error_o !== 1'b1 || resp_data_o !== da || alu_valid_o !== 1'b1)
          $display("FAIL sim_err_resp: rv=%b err=%b data=%h valid=%b required 1000 1 %h 1",
                   resp_valid_o, resp_error_o, resp_data_o, alu_valid_o, da);
        else n_pass++;
      end
      if (k == 5) begin
        n_checks++;
        if (resp_valid_o !== 4'b0001 || resp_error_o !== 1'b0 || alu_valid_o !== 1'b1)
          $display("FAIL sim_hold_count: rv=%b err=%b valid=%b required 0001 0 1",
                   resp_valid_o, resp_error_o, alu_valid_o);
        else n_pass++;
      end
      cycle();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      rand_req_data();
      flush = ($urandom_range(0, 15) == 0);
      alu_ready = 1'($urandom_range(0, 1));
      resp_v = ($urandom_range(0, 2) == 0);
      resp_tag = 2'($urandom_range(0, 3));
      resp_data = $urandom;
      resp_err = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (req_ready_o !== m_ready() || alu_valid_o !== m_alu_valid() || busy_o !== (mq_data.size() > 0 || m_out > 0))
        $display("FAIL rand_ctrl k=%0d: rdy=%b valid=%b busy=%b required %b %b %b", k, req_ready_o,
                 alu_valid_o, busy_o, m_ready(), m_alu_valid(), (mq_data.size() > 0 || m_out > 0));
      else n_pass++;
      if (m_alu_valid()) begin
        n_checks++;
        if (alu_data_o !== mq_data[0] || alu_tag_o !== 2'(mq_tag[0]))
          $display("FAIL rand_head k=%0d: data=%h tag=%0d required %h %0d", k, alu_data_o, alu_tag_o,
                   mq_data[0], mq_tag[0]);
        else n_pass++;
      end
      n_checks++;
      if (resp_valid_o !== m_rv || resp_data_o !== m_rd || resp_error_o !== m_re)
        $display("FAIL rand_resp k=%0d: rv=%b data=%h err=%b required %b %h %b", k, resp_valid_o,
                 resp_data_o, resp_error_o, m_rv, m_rd, m_re);
      else n_pass++;
      n_checks++;
      if (issued_cnt_o !== m_issued || stall_cnt_o !== m_stall)
        $display("FAIL rand_counters k=%0d: issued=%0d stall=%0d required %0d %0d", k, issued_cnt_o,
                 stall_cnt_o, m_issued, m_stall);
      else n_pass++;
      cycle();
    end
  endtask

  task automatic test_reset_midop();
    do_reset(); alu_ready = 1'b1; req_valid = 4'hF; rand_req_data();
    repeat (3) cycle();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || alu_valid_o !== 1'b0 || issued_cnt_o !== 32'd0)
      $display("FAIL midop_reset: busy=%b valid=%b issued=%0d required 0 0 0", busy_o, alu_valid_o, issued_cnt_o);
    else n_pass++;
    @(posedge clk); #1;
    clear_inputs(); rst_n = 1'b1; model_reset();
    resp_v = 1'b1; resp_tag = 2'd1; resp_data = 32'hDEAD_BEEF;
    cycle();
    resp_v = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_valid_o !== 4'b0000 || busy_o !== 1'b0)
      $display("FAIL midop_stale_resp: rv=%b busy=%b required 0000 0", resp_valid_o, busy_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full_fifo();
    test_outstanding_limit();
    test_flush();
    test_simultaneous();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
